// File: rtl/multdiv_issue_ctrl_pkg.sv
// multdiv_issue_ctrl_pkg: opcodes, register indices, state encoding and decode helpers for the multdiv issue controller
package multdiv_issue_ctrl_pkg;
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW = 5'b01000;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;
  localparam logic [4:0] RSTATUS = 5'd30;
  localparam logic [4:0] RA = 5'd31;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_WB = 2'd2;

  typedef struct packed {
    logic we;
    logic [4:0] rg;
    logic [31:0] data;
  } wb_t;

  function automatic logic is_mul(input logic [31:0] i);
    return i[31:27] == OP_RTYPE && i[6:2] == ALU_MUL;
  endfunction

  function automatic logic is_div(input logic [31:0] i);
    return i[31:27] == OP_RTYPE && i[6:2] == ALU_DIV;
  endfunction

  // {valid, register} written by an instruction
  function automatic logic [5:0] dest(input logic [31:0] i);
    logic [4:0] op;
    op = i[31:27];
    return (op == OP_RTYPE || op == OP_ADDI || op == OP_LW) ? {1'b1, i[26:22]} :
           op == OP_JAL ? {1'b1, RA} :
           op == OP_SETX ? {1'b1, RSTATUS} : 6'd0;
  endfunction
endpackage

// File: rtl/multdiv_hazard_check.sv
// multdiv_hazard_check: flags D/X instructions that must wait for an in-flight mul/div
module multdiv_hazard_check
  import multdiv_issue_ctrl_pkg::*;
(
  input  logic [4:0]  prd,
  input  logic        busy,
  input  logic [31:0] fd_instr,
  input  logic [31:0] dx_instr,
  output logic        hazard
);
  function automatic logic conflict(input logic [31:0] i, input logic [4:0] r);
    logic [5:0] d;
    d = dest(i);
    return ((i[21:17] == r || i[16:12] == r) && r != 5'd0) || is_mul(i) || is_div(i) ||
           (d[5] && ((d[4:0] == r && r != 5'd0) || d[4:0] == RSTATUS));
  endfunction

  // hazard only matters while an operation is outstanding
  always_comb hazard = busy && (conflict(fd_instr, prd) || conflict(dx_instr, prd));
endmodule

// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: issues mul/div from X, waits for the result and retires it through the regfile write port (optional MULTDIV_SCOREBOARD_EN)
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int          MAX_CYCLES   = 40,
  parameter logic [31:0] MUL_ERR_CODE = 32'd4,
  parameter logic [31:0] DIV_ERR_CODE = 32'd5,
  parameter logic [31:0] TMO_ERR_CODE = 32'd7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_instr,
  input  logic        dx_valid,
  input  logic [31:0] fd_instr,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic        stall,
  output logic        wb_steal,
  output logic        wb_we,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        busy
);
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_CYCLES);
  localparam logic [CW-1:0] CLAST = CW'(MAX_CYCLES - 1);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [4:0] rd_q;
  logic div_q;
  wb_t wb_q;
  logic is_m, is_d, issue, tmo, ok;
  assign is_m = is_mul(dx_instr);
  assign is_d = is_div(dx_instr);
  assign issue = reset && dx_valid && (is_m || is_d) && state == S_IDLE;
  assign tmo = state == S_BUSY && cnt == CLAST;
  assign ok = md_ready && !md_exception;

  // issue / wait / writeback sequencing; a result arriving on the timeout cycle still wins
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      rd_q <= '0;
      div_q <= 1'b0;
      wb_q <= '0;
    end else if (issue) begin
      state <= S_BUSY;
      cnt <= '0;
      rd_q <= dx_instr[26:22];
      div_q <= is_d;
    end else if (state == S_BUSY) begin
      cnt <= cnt == CMAX ? cnt : cnt + 1'b1;
      if (md_ready || tmo) begin
        state <= S_WB;
        wb_q.we <= !ok || rd_q != 5'd0;
        wb_q.rg <= ok ? rd_q : RSTATUS;
        wb_q.data <= !md_ready ? TMO_ERR_CODE : ok ? md_result : div_q ? DIV_ERR_CODE : MUL_ERR_CODE;
      end
    end else
      state <= S_IDLE;

  // start pulses and the write-port steal are pure functions of state and X-stage decode
  always_comb begin
    md_ctrl_mult = issue && is_m;
    md_ctrl_div = issue && is_d;
    busy = state == S_BUSY;
    wb_steal = state == S_WB;
    wb_we = wb_steal && wb_q.we;
    wb_reg = wb_steal ? wb_q.rg : 5'd0;
    wb_data = wb_steal ? wb_q.data : 32'd0;
  end

`ifdef MULTDIV_SCOREBOARD_EN
  logic hazard;
  multdiv_hazard_check u_hazard (
    .prd(rd_q),
    .busy(busy),
    .fd_instr(fd_instr),
    .dx_instr(dx_instr),
    .hazard(hazard)
  );
  // the mul/div leaves X at issue; only dependent or conflicting instructions wait
  always_comb stall = hazard || wb_steal;
`else
  logic unused_fd;
  assign unused_fd = ^fd_instr;
  // blocking: the pipeline is frozen from issue through writeback
  always_comb stall = issue || busy || wb_steal;
`endif
endmodule
